udp_sweep_ctrl: RTL

UDP_SWEEP_CTRL -- requirements
Module: udp_sweep_ctrl

---
 rtl/udp_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/udp_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// udp_sweep_ctrl
//
// Exhaustive truth-table sweeper for a 4-input function whose output reaches
// us through a shared tri-state buffer. Each sweep walks a 5-bit step index
// idx from 0 to 31:
//   - phase 0 (idx[4] = 0): buffer released. The weak pull-down should read 0.
//     A 1 means something else is driving the net, and float_err is flagged.
//   - phase 1 (idx[4] = 1): buffer enabled. f_in is captured into
//     result[idx[3:0]].
// Every step is DRIVE, then SETTLE_CYCLES cycles of SETTLE, then SAMPLE.
//
// Parameters
//   SETTLE_CYCLES : wait cycles between driving a vector and sampling (0..15)
//   EXPECTED      : golden truth table, bit i = expected f for x = i
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle sweep request (ignored unless idle)
//   abort        : cancel a running sweep
//   f_in         : function output read back from the shared net
//   x_out[3:0]   : function inputs (x_out[3] = a ... x_out[0] = d)
//   en_out       : tri-state buffer enable
//   busy         : high while a sweep runs
//   done         : one-cycle pulse at sweep completion
//   result[15:0] : captured truth table
//   float_err    : net read 1 while the buffer was released (sticky)
//
// Optional build macro UDP_SWEEP_COMPARE_EN adds:
//   pass         : registered in DONE, no mismatches and no float error
//   mismatch_cnt : phase-1 samples differing from EXPECTED, saturates at 16
// -----------------------------------------------------------------------------
module udp_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h55F2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    output logic [3:0]  x_out,
    output logic        en_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        float_err
`ifdef UDP_SWEEP_COMPARE_EN
    ,
    output logic        pass,
    output logic [4:0]  mismatch_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic       HAS_SETTLE  = (SETTLE_CYCLES != 32'd0);
    localparam logic [4:0] LAST_IDX    = 5'd31;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  idx_r;
    logic [3:0]  settle_cnt_r;
    logic        accept_s;
    logic [4:0]  idx_inc_s;

    assign idx_inc_s = idx_r + 5'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. Abort wins over every other transition out of a busy state.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_s  = DRIVE;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (HAS_SETTLE) begin
                    state_s = SETTLE;
                end else begin
                    state_s = SAMPLE;
                end
            end
            SETTLE: begin
                // The counter is loaded with SETTLE_CYCLES in DRIVE. Leaving at 1 gives
                // exactly SETTLE_CYCLES cycles here.
                if (abort) begin
                    state_s = IDLE;
                end else if (settle_cnt_r <= 4'd1) begin
                    state_s = SAMPLE;
                end else begin
                    state_s = SETTLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = DRIVE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Step index, settle counter, drive outputs, status flags and captured table.
    // x_out/en_out are loaded on the edge that enters DRIVE, so they equal idx
    // for the whole step.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r        <= 5'd0;
            settle_cnt_r <= 4'd0;
            x_out        <= 4'd0;
            en_out       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 16'd0;
            float_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_r == IDLE) begin
                if (accept_s) begin
                    idx_r     <= 5'd0;
                    x_out     <= 4'd0;
                    en_out    <= 1'b0;
                    busy      <= 1'b1;
                    result    <= 16'd0;
                    float_err <= 1'b0;
                end
            end else if (state_r == DONE) begin
                busy <= 1'b0;
            end else if (abort) begin
                // Drop the net and return to idle. Partial results are kept.
                x_out  <= 4'd0;
                en_out <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state_r)
                    DRIVE: begin
                        settle_cnt_r <= SETTLE_LOAD;
                    end
                    SETTLE: begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                    SAMPLE: begin
                        if (idx_r[4]) begin
                            result[idx_r[3:0]] <= f_in;
                        end else if (f_in) begin
                            float_err <= 1'b1;
                        end
                        if (idx_r == LAST_IDX) begin
                            x_out  <= 4'd0;
                            en_out <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            idx_r           <= idx_inc_s;
                            {en_out, x_out} <= idx_inc_s;
                        end
                    end
                    default: begin
                        settle_cnt_r <= settle_cnt_r;
                    end
                endcase
            end
        end
    end

`ifdef UDP_SWEEP_COMPARE_EN
    // Golden-table comparison. mismatch_cnt counts phase-1 disagreements, and pass
    // is latched once the sweep reaches DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_cnt <= 5'd0;
            pass         <= 1'b0;
        end else if (accept_s) begin
            mismatch_cnt <= 5'd0;
            pass         <= 1'b0;
        end else begin
            if ((state_r == SAMPLE) && !abort && idx_r[4] &&
                (f_in != EXPECTED[idx_r[3:0]]) && (mismatch_cnt < 5'd16)) begin
                mismatch_cnt <= mismatch_cnt + 5'd1;
            end
            if (state_r == DONE) begin
                pass <= (mismatch_cnt == 5'd0) && !float_err;
            end
        end
    end
`else
    // EXPECTED only feeds the comparison logic. It is folded into an unused net
    // here so that the default build carries no dangling parameter.
    logic unused_expected_s;
    assign unused_expected_s = ^EXPECTED;
`endif

endmodule
